// File: rtl/hv_desat_det_if.sv
// hv_desat_det_if
//   Bundles the configuration, command, comparator and status signals of the
//   desaturation detector. clk and rst_n are not part of the bundle.
//   master : drives desat_dig_en, desat_blanking, desat_deglitch_sel,
//            pwm_on, desat_cmp, fault_clr; observes the status outputs.
//   slave  : the detector; observes the inputs, drives desat_flt,
//            desat_flt_pls, desat_blank_act (and desat_flt_cnt when
//            HV_DESAT_FLT_CNT_EN is defined).
interface hv_desat_det_if;
    logic       desat_dig_en;
    logic [2:0] desat_blanking;
    logic [2:0] desat_deglitch_sel;
    logic       pwm_on;
    logic       desat_cmp;
    logic       fault_clr;
    logic       desat_flt;
    logic       desat_flt_pls;
    logic       desat_blank_act;
`ifdef HV_DESAT_FLT_CNT_EN
    logic [7:0] desat_flt_cnt;
`endif

    modport master (
`ifdef HV_DESAT_FLT_CNT_EN
        input  desat_flt_cnt,
`endif
        output desat_dig_en, desat_blanking, desat_deglitch_sel,
        output pwm_on, desat_cmp, fault_clr,
        input  desat_flt, desat_flt_pls, desat_blank_act
    );

    modport slave (
`ifdef HV_DESAT_FLT_CNT_EN
        output desat_flt_cnt,
`endif
        input  desat_dig_en, desat_blanking, desat_deglitch_sel,
        input  pwm_on, desat_cmp, fault_clr,
        output desat_flt, desat_flt_pls, desat_blank_act
    );
endinterface

// File: rtl/hv_desat_det.sv
// hv_desat_det
//   Gate-driver desaturation detector. After the driver turns on, the
//   comparator is ignored for a blanking window, then must stay high for a
//   deglitch run before a latched fault is raised. The fault is cleared by
//   fault_clr while the driver is commanded off.
// Ports
//   clk    : block clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : hv_desat_det_if.slave (config, pwm_on, desat_cmp, fault_clr,
//            desat_flt, desat_flt_pls, desat_blank_act)
// Optional feature
//   HV_DESAT_FLT_CNT_EN : adds the 8-bit saturating fault counter
//                         desat_flt_cnt to the interface.
module hv_desat_det #(
    parameter int BLK_STEP = 24,
    parameter int DGL_STEP = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    hv_desat_det_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_MON,
        ST_DGL,
        ST_FAULT
    } state_t;

    localparam logic [11:0] BLK_STEP_W = 12'(BLK_STEP);
    localparam logic [7:0]  DGL_STEP_W = 8'(DGL_STEP);

    state_t      state_q, state_d;
    logic        cmp_m_q, cmp_s_q;
    logic [11:0] blank_cnt_q, blank_cnt_d;
    logic [11:0] blank_len_q, blank_len_d;
    logic [7:0]  dgl_cnt_q, dgl_cnt_d;
    logic [7:0]  dgl_len_q, dgl_len_d;
    logic        flt_q, flt_d;
    logic        pls_q, pls_d;
    logic        blank_act_q, blank_act_d;
    logic        armed;

    // Detection is only meaningful while enabled and the gate is commanded on.
    assign armed = bus.pwm_on & bus.desat_dig_en;

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        blank_len_d = blank_len_q;
        dgl_cnt_d   = dgl_cnt_q;
        dgl_len_d   = dgl_len_q;
        flt_d       = flt_q;
        pls_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (armed) begin
                    state_d     = ST_BLANK;
                    blank_cnt_d = '0;
                    blank_len_d = (12'(bus.desat_blanking) + 12'd1) * BLK_STEP_W;
                end
            end
            ST_BLANK: begin
                if (!armed) begin
                    state_d     = ST_IDLE;
                    blank_cnt_d = '0;
                    dgl_cnt_d   = '0;
                end else if (blank_cnt_q + 12'd1 == blank_len_q) begin
                    // Deglitch length is latched here so later selector
                    // changes cannot shorten a run already in progress.
                    state_d     = ST_MON;
                    blank_cnt_d = '0;
                    dgl_cnt_d   = '0;
                    dgl_len_d   = (8'(bus.desat_deglitch_sel) + 8'd1) * DGL_STEP_W;
                end else begin
                    blank_cnt_d = blank_cnt_q + 12'd1;
                end
            end
            ST_MON: begin
                if (!armed) begin
                    state_d   = ST_IDLE;
                    dgl_cnt_d = '0;
                end else if (cmp_s_q) begin
                    if (dgl_len_q == 8'd1) begin
                        state_d   = ST_FAULT;
                        flt_d     = 1'b1;
                        pls_d     = 1'b1;
                        dgl_cnt_d = '0;
                    end else begin
                        state_d   = ST_DGL;
                        dgl_cnt_d = 8'd1;
                    end
                end
            end
            ST_DGL: begin
                if (!armed) begin
                    state_d   = ST_IDLE;
                    dgl_cnt_d = '0;
                end else if (!cmp_s_q) begin
                    state_d   = ST_MON;
                    dgl_cnt_d = '0;
                end else if (dgl_cnt_q + 8'd1 == dgl_len_q) begin
                    state_d   = ST_FAULT;
                    flt_d     = 1'b1;
                    pls_d     = 1'b1;
                    dgl_cnt_d = '0;
                end else begin
                    dgl_cnt_d = dgl_cnt_q + 8'd1;
                end
            end
            ST_FAULT: begin
                // Clearing is only honoured with the gate commanded off.
                if (bus.fault_clr && !bus.pwm_on) begin
                    state_d = ST_IDLE;
                    flt_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        blank_act_d = (state_d == ST_BLANK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmp_m_q     <= 1'b0;
            cmp_s_q     <= 1'b0;
            blank_cnt_q <= '0;
            blank_len_q <= '0;
            dgl_cnt_q   <= '0;
            dgl_len_q   <= '0;
            flt_q       <= 1'b0;
            pls_q       <= 1'b0;
            blank_act_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_m_q     <= bus.desat_cmp;
            cmp_s_q     <= cmp_m_q;
            blank_cnt_q <= blank_cnt_d;
            blank_len_q <= blank_len_d;
            dgl_cnt_q   <= dgl_cnt_d;
            dgl_len_q   <= dgl_len_d;
            flt_q       <= flt_d;
            pls_q       <= pls_d;
            blank_act_q <= blank_act_d;
        end
    end

    assign bus.desat_flt       = flt_q;
    assign bus.desat_flt_pls   = pls_q;
    assign bus.desat_blank_act = blank_act_q;

`ifdef HV_DESAT_FLT_CNT_EN
    logic [7:0] flt_cnt_q, flt_cnt_d;

    // Counts fault entries, sticking at 255; only reset clears it.
    always_comb begin
        flt_cnt_d = flt_cnt_q;
        if (pls_d && (flt_cnt_q != 8'hFF)) begin
            flt_cnt_d = flt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign bus.desat_flt_cnt = flt_cnt_q;
`endif
endmodule

// File: tb/tb_hv_desat_det.sv
// tb_hv_desat_det
//   Directed scenarios with literal expectations, followed by randomized
//   stimulus checked every cycle against a cycle-count based model of the
//   detector behaviour.
module tb_hv_desat_det;
    localparam int BLK_STEP = 24;
    localparam int DGL_STEP = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    hv_desat_det_if bus();

    hv_desat_det #(.BLK_STEP(BLK_STEP), .DGL_STEP(DGL_STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Tracks edges elapsed since the gate was armed; blanking is simply
    // "fewer than blank_len edges elapsed", and the deglitch filter is the
    // length of the current run of synchronized-high samples.
    int m_s1, m_s2, m_fault, m_pls, m_active, m_since, m_run;
    int m_blank_len, m_dgl_len, m_cnt, m_blank_act;

    always @(posedge clk) begin
        int cs;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_fault = 0; m_pls = 0; m_active = 0;
            m_since = 0; m_run = 0; m_cnt = 0;
            m_blank_len = 0; m_dgl_len = 0;
        end else begin
            cs   = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(bus.desat_cmp);
            m_pls = 0;
            if (m_fault != 0) begin
                if (bus.fault_clr && !bus.pwm_on) m_fault = 0;
            end else if (m_active != 0) begin
                if (!bus.pwm_on || !bus.desat_dig_en) begin
                    m_active = 0;
                end else begin
                    m_since++;
                    if (m_since == m_blank_len) begin
                        m_dgl_len = (int'(bus.desat_deglitch_sel) + 1) * DGL_STEP;
                        m_run = 0;
                    end else if (m_since > m_blank_len) begin
                        if (cs != 0) begin
                            m_run++;
                            if (m_run == m_dgl_len) begin
                                m_fault = 1; m_pls = 1; m_active = 0;
                                if (m_cnt < 255) m_cnt++;
                            end
                        end else begin
                            m_run = 0;
                        end
                    end
                end
            end else if (bus.desat_dig_en && bus.pwm_on) begin
                m_active = 1;
                m_since = 0;
                m_blank_len = (int'(bus.desat_blanking) + 1) * BLK_STEP;
            end
        end
        m_blank_act = ((m_active != 0) && (m_since < m_blank_len)) ? 1 : 0;

        #2;
        if (rst_n) begin
            n_cmp++;
            if (int'(bus.desat_flt) != m_fault) begin
                n_fail++;
                $display("FAIL model_flt t=%0t got=%0d exp=%0d", $time, bus.desat_flt, m_fault);
            end
            n_cmp++;
            if (int'(bus.desat_flt_pls) != m_pls) begin
                n_fail++;
                $display("FAIL model_pls t=%0t got=%0d exp=%0d", $time, bus.desat_flt_pls, m_pls);
            end
            n_cmp++;
            if (int'(bus.desat_blank_act) != m_blank_act) begin
                n_fail++;
                $display("FAIL model_blank_act t=%0t got=%0d exp=%0d", $time, bus.desat_blank_act, m_blank_act);
            end
`ifdef HV_DESAT_FLT_CNT_EN
            n_cmp++;
            if (int'(bus.desat_flt_cnt) != m_cnt) begin
                n_fail++;
                $display("FAIL model_cnt t=%0t got=%0d exp=%0d", $time, bus.desat_flt_cnt, m_cnt);
            end
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else begin
            $display("ok   %s got=%0d", name, got);
        end
    endtask

    initial begin
        int any_flt, any_blank;
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.desat_dig_en = 1'b1;
        bus.desat_blanking = 3'd3;
        bus.desat_deglitch_sel = 3'd0;
        bus.pwm_on = 1'b0;
        bus.desat_cmp = 1'b1;
        bus.fault_clr = 1'b0;
        tick(3);
        chk("reset_flt", int'(bus.desat_flt), 0);
        chk("reset_pls", int'(bus.desat_flt_pls), 0);
        chk("reset_blank_act", int'(bus.desat_blank_act), 0);
        rst_n = 1'b1;
        tick(4);

        // Blanking 3 (96 edges), deglitch 8, comparator stuck high.
        bus.pwm_on = 1'b1;
        tick(1);
        chk("blank_entry_act", int'(bus.desat_blank_act), 1);
        any_flt = 0;
        for (int k = 1; k <= 103; k++) begin
            tick(1);
            if (bus.desat_flt) any_flt = 1;
        end
        chk("no_fault_before_104", any_flt, 0);
        tick(1);
        chk("fault_at_104", int'(bus.desat_flt), 1);
        chk("pulse_at_104", int'(bus.desat_flt_pls), 1);
        tick(1);
        chk("pulse_single", int'(bus.desat_flt_pls), 0);

        // Clear attempts in FAULT.
        bus.fault_clr = 1'b1;
        tick(1);
        chk("clr_with_pwm_ignored", int'(bus.desat_flt), 1);
        bus.pwm_on = 1'b0;
        tick(1);
        chk("clr_pwm_off_clears", int'(bus.desat_flt), 0);
        bus.fault_clr = 1'b0;

        // Deglitch: 7-high run rejected, 8-high run faults.
        bus.desat_blanking = 3'd0;
        bus.desat_cmp = 1'b0;
        bus.pwm_on = 1'b1;
        tick(30);
        bus.desat_cmp = 1'b1; tick(7);
        bus.desat_cmp = 1'b0; tick(5);
        chk("dgl_run7_no_fault", int'(bus.desat_flt), 0);
        bus.desat_cmp = 1'b1; tick(8);
        bus.desat_cmp = 1'b0; tick(3);
        chk("dgl_run8_fault", int'(bus.desat_flt), 1);
        bus.pwm_on = 1'b0; bus.fault_clr = 1'b1; tick(1);
        bus.fault_clr = 1'b0; tick(1);

        // pwm_on drop mid-deglitch aborts, next turn-on restarts blanking.
        bus.pwm_on = 1'b1; tick(30);
        bus.desat_cmp = 1'b1; tick(7);
        bus.pwm_on = 1'b0; tick(1);
        chk("pwm_drop_no_fault", int'(bus.desat_flt), 0);
        chk("pwm_drop_idle", int'(bus.desat_blank_act), 0);
        bus.pwm_on = 1'b1; bus.desat_cmp = 1'b0; tick(1);
        chk("restart_blanking", int'(bus.desat_blank_act), 1);
        bus.pwm_on = 1'b0; tick(2);

        // Detection disabled.
        bus.desat_dig_en = 1'b0; bus.pwm_on = 1'b1; bus.desat_cmp = 1'b1;
        any_flt = 0; any_blank = 0;
        for (int k = 0; k < 1000; k++) begin
            tick(1);
            if (bus.desat_flt) any_flt = 1;
            if (bus.desat_blank_act) any_blank = 1;
        end
        chk("disabled_no_fault", any_flt, 0);
        chk("disabled_no_blank", any_blank, 0);

        // Reset while in FAULT.
        bus.desat_dig_en = 1'b1; tick(40);
        chk("fault_before_reset", int'(bus.desat_flt), 1);
        rst_n = 1'b0; tick(1);
        chk("reset_in_fault_flt", int'(bus.desat_flt), 0);
        chk("reset_in_fault_blank", int'(bus.desat_blank_act), 0);
        rst_n = 1'b1; bus.pwm_on = 1'b0; tick(2);
        chk("after_reset_flt", int'(bus.desat_flt), 0);

`ifdef HV_DESAT_FLT_CNT_EN
        for (int r = 0; r < 3; r++) begin
            bus.pwm_on = 1'b1; tick(40);
            bus.pwm_on = 1'b0; bus.fault_clr = 1'b1; tick(1);
            bus.fault_clr = 1'b0; tick(1);
        end
        chk("flt_cnt_three", int'(bus.desat_flt_cnt), 3);
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; tick(1);
        chk("flt_cnt_reset", int'(bus.desat_flt_cnt), 0);
`endif

        // Randomized phase.
        for (int k = 0; k < 12000; k++) begin
            if ($urandom_range(0, 199) == 0) bus.pwm_on = ~bus.pwm_on;
            if ($urandom_range(0, 1999) == 0) bus.desat_dig_en = ~bus.desat_dig_en;
            if ($urandom_range(0, 4) == 0) bus.desat_cmp = ~bus.desat_cmp;
            bus.fault_clr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) bus.desat_blanking = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) bus.desat_deglitch_sel = 3'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 4999) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hv_desat_det.md
HV_DESAT_DET -- requirements
Module: hv_desat_det

Interface
REQ-001 Parameter BLK_STEP, default 24, gives the clk cycles per desat_blanking LSB.
REQ-002 Parameter DGL_STEP, default 8, gives the clk cycles per desat_deglitch_sel LSB.
REQ-003 clk  input  1  single block clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 desat_dig_en  input  1  detection enable (config6 field).
REQ-006 desat_blanking  input  3  blanking select (config6 field).
REQ-007 desat_deglitch_sel  input  3  deglitch select (config7 field).
REQ-008 pwm_on  input  1  synchronous gate-on command; high = driver on.
REQ-009 desat_cmp  input  1  asynchronous analog desat comparator output.
REQ-010 fault_clr  input  1  synchronous one-cycle clear request.
REQ-011 desat_flt  output  1  latched desat fault level.
REQ-012 desat_flt_pls  output  1  one-cycle pulse on fault entry.
REQ-013 desat_blank_act  output  1  high while in BLANK.

Function
REQ-014 desat_cmp SHALL pass through a 2-flop synchronizer (cmp_s) before any use.
REQ-015 blank_len SHALL be (desat_blanking+1)*BLK_STEP cycles, held in a 12-bit counter.
REQ-016 dgl_len SHALL be (desat_deglitch_sel+1)*DGL_STEP cycles, held in an 8-bit counter.
REQ-017 blank_len SHALL be captured on BLANK entry and dgl_len on MON entry; selector changes mid-count SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, BLANK, MON, DGL and FAULT.
REQ-019 IDLE -> BLANK on an edge with desat_dig_en=1 and pwm_on=1; the blank counter clears.
REQ-020 BLANK SHALL ignore cmp_s and go to MON on the blank_len-th edge after BLANK entry.
REQ-021 MON -> DGL on an edge sampling cmp_s=1, with the deglitch count set to 1.
REQ-022 DGL: each edge with cmp_s=1 increments the count; cmp_s=0 returns to MON with the count cleared.
REQ-023 DGL -> FAULT on the edge of the dgl_len-th consecutive cmp_s=1 sample; with dgl_len=1, MON -> FAULT directly.
REQ-024 In BLANK, MON or DGL, pwm_on=0 or desat_dig_en=0 SHALL force IDLE with counters cleared; this has priority over other transitions.
REQ-025 FAULT entry SHALL set desat_flt=1 and pulse desat_flt_pls for exactly one cycle.
REQ-026 FAULT SHALL be left only on fault_clr=1 with pwm_on=0, going to IDLE with desat_flt=0 on that edge.
REQ-027 In FAULT, fault_clr with pwm_on=1 SHALL be ignored, and desat_dig_en=0 SHALL NOT clear the fault.
REQ-028 fault_clr in any state other than FAULT SHALL have no effect.
REQ-029 Outputs SHALL be registered; desat_blank_act equals (state==BLANK).

Reset
REQ-030 rst_n low SHALL force IDLE, clear the synchronizer and counters, and drive desat_flt=0, desat_flt_pls=0 and desat_blank_act=0.
REQ-031 Reset during any state, including FAULT, SHALL discard all history; after release, detection restarts from IDLE.

Configuration
REQ-032 Macro HV_DESAT_FLT_CNT_EN, when defined, SHALL add output desat_flt_cnt (8 bits).
REQ-033 desat_flt_cnt SHALL increment on each FAULT entry, saturate at 255, and clear only on rst_n.
REQ-034 When HV_DESAT_FLT_CNT_EN is undefined, the port and its counter SHALL be absent and all other behaviour is identical.

Verification
REQ-035 Blanking=3, deglitch=0, cmp held high, pwm_on rising -> no fault for 96 edges after BLANK entry; desat_flt=1 and one pulse at edge 104.
REQ-036 MON, deglitch=0 (dgl_len 8), cmp_s high for 7 cycles then low -> no fault; a following 8-cycle high -> fault.
REQ-037 In DGL with count 5, pwm_on drops -> IDLE, no fault; next pwm_on restarts blanking and desat_blank_act=1.
REQ-038 In FAULT, fault_clr with pwm_on=1 -> desat_flt stays 1; with pwm_on=0 -> desat_flt=0 on the next edge, state IDLE.
REQ-039 desat_dig_en=0, pwm_on=1, cmp high for 1000 cycles -> desat_flt stays 0 and desat_blank_act stays 0.
REQ-040 HV_DESAT_FLT_CNT_EN defined, three fault/clear cycles -> desat_flt_cnt=3; rst_n pulse -> 0.
